m_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the single-issue RV32 integer datapath (PC register, PC+4 adder, instruction memory, register file, ALU adder, data memory). It steps each instruction through IF/ID/EX/MEM/WB and issues the enables and selects for PC, IR, register-file and data-memory updates. It handshakes with instruction and data memories that have variable latency, and keeps cycle and retired-instruction counters for the bench.

---
 rtl/m_multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_m_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32 datapath: all outputs are decoded from state plus acks.
// Latency: R/I 4, load 5, store 4, branch 3 cycles with single-cycle acks; it waits on imem/dmem acks, and an imem wait can time out.
module m_multicycle_ctrl #(
    parameter int CNT_W        = 32,
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic             w_clock,
    input  logic             w_reset,
    input  logic             w_run,
    input  logic [31:0]      w_ir,
    input  logic             w_br_taken,
    input  logic             w_imem_ack,
    input  logic             w_dmem_ack,
    output logic             w_imem_req,
    output logic             w_ir_we,
    output logic             w_pc_we,
    output logic             w_pc_sel,
    output logic             w_rf_we,
    output logic             w_dmem_req,
    output logic             w_dmem_we,
    output logic             w_halted,
    output logic             w_illegal,
    output logic             w_fault,
    output logic [2:0]       w_state,
    output logic [CNT_W-1:0] w_cycle_cnt,
    output logic [CNT_W-1:0] w_retired
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [31:0]      TO_LIM  = 32'(IMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;
    logic [31:0]      to_cnt_q, to_cnt_d;
    logic [31:0]      to_cnt_inc;
    logic [6:0]       opcode;
    logic             retire;
    logic             leave_to_if;
    logic             active;
    logic             unused_ir;

    assign opcode      = w_ir[6:0];
    assign unused_ir   = ^w_ir[31:12];
    assign to_cnt_inc  = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 32'd1;
    assign leave_to_if = w_run;

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        fault_d    = fault_q;
        to_cnt_d   = '0;
        retire     = 1'b0;
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        w_rf_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_halted   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_run) state_d = S_IF;
            end
            S_IF: begin
                w_imem_req = 1'b1;
                if (w_imem_ack) begin
                    w_ir_we = 1'b1;
                    state_d = S_ID;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if ((IMEM_TIMEOUT != 0) && (to_cnt_inc >= TO_LIM)) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_ID: begin
                case (opcode)
                    OP_R, OP_I, OP_LD, OP_ST, OP_BR: state_d = S_EX;
                    OP_SYS: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_BR: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = w_br_taken;
                        retire   = 1'b1;
                        state_d  = leave_to_if ? S_IF : S_IDLE;
                    end
                    // IR changed under us after ID: treat as illegal rather than guess
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (opcode == OP_ST);
                if (w_dmem_ack) begin
                    if (opcode == OP_ST) begin
                        w_pc_we = 1'b1;
                        retire  = 1'b1;
                        state_d = leave_to_if ? S_IF : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we = (w_ir[11:7] != 5'd0);
                w_pc_we = 1'b1;
                retire  = 1'b1;
                state_d = leave_to_if ? S_IF : S_IDLE;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active      = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                      (state_q == S_MEM) || (state_q == S_WB);
        cycle_cnt_d = (active && (cycle_cnt_q != '1)) ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;
        retired_d   = (retire && (retired_q != '1)) ? retired_q + CNT_ONE : retired_q;
    end

    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            fault_q     <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            retired_q   <= retired_d;
            illegal_q   <= illegal_d;
            fault_q     <= fault_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign w_state     = state_q;
    assign w_cycle_cnt = cycle_cnt_q;
    assign w_retired   = retired_q;
    assign w_illegal   = illegal_q;
    assign w_fault     = fault_q;
endmodule

// File: tb/tb_m_multicycle_ctrl.sv
// Bench for m_multicycle_ctrl: directed table, randomized instruction stream against a per-instruction
// latency/effect model, and hand sequences for reset, halt, timeout and run-deassert corners.
module tb_m_multicycle_ctrl;
    logic        w_clock = 1'b0;
    logic        w_reset, w_run, w_br_taken, w_imem_ack, w_dmem_ack;
    logic [31:0] w_ir;
    logic        w_imem_req, w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_dmem_req, w_dmem_we;
    logic        w_halted, w_illegal, w_fault;
    logic [2:0]  w_state;
    logic [31:0] w_cycle_cnt, w_retired;

    logic        s_unused_imem_req, s_unused_ir_we, s_unused_pc_we, s_unused_pc_sel, s_unused_rf_we;
    logic        s_unused_dmem_req, s_unused_dmem_we, s_unused_illegal, s_unused_fault;
    logic        s_halted;
    logic [2:0]  s_state;
    logic [2:0]  s_cycle_cnt, s_unused_retired;

    int total = 0;
    int bad   = 0;

    always #5 w_clock = ~w_clock;

    m_multicycle_ctrl #(.CNT_W(32), .IMEM_TIMEOUT(8)) dut (
        .w_clock(w_clock), .w_reset(w_reset), .w_run(w_run), .w_ir(w_ir),
        .w_br_taken(w_br_taken), .w_imem_ack(w_imem_ack), .w_dmem_ack(w_dmem_ack),
        .w_imem_req(w_imem_req), .w_ir_we(w_ir_we), .w_pc_we(w_pc_we), .w_pc_sel(w_pc_sel),
        .w_rf_we(w_rf_we), .w_dmem_req(w_dmem_req), .w_dmem_we(w_dmem_we),
        .w_halted(w_halted), .w_illegal(w_illegal), .w_fault(w_fault), .w_state(w_state),
        .w_cycle_cnt(w_cycle_cnt), .w_retired(w_retired)
    );

    // Narrow counters and no fetch timeout: checks saturation and the disabled-timeout case
    m_multicycle_ctrl #(.CNT_W(3), .IMEM_TIMEOUT(0)) dut_s (
        .w_clock(w_clock), .w_reset(w_reset), .w_run(w_run), .w_ir(w_ir),
        .w_br_taken(w_br_taken), .w_imem_ack(w_imem_ack), .w_dmem_ack(w_dmem_ack),
        .w_imem_req(s_unused_imem_req), .w_ir_we(s_unused_ir_we), .w_pc_we(s_unused_pc_we),
        .w_pc_sel(s_unused_pc_sel), .w_rf_we(s_unused_rf_we), .w_dmem_req(s_unused_dmem_req),
        .w_dmem_we(s_unused_dmem_we), .w_halted(s_halted), .w_illegal(s_unused_illegal),
        .w_fault(s_unused_fault), .w_state(s_state), .w_cycle_cnt(s_cycle_cnt),
        .w_retired(s_unused_retired)
    );

    typedef struct {
        logic [31:0] ir;
        logic        bt;
        int          di;
        int          dd;
        int          cyc;
        int          rf;
        int          sel;
        int          dreq;
        int          dwe;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clock);
        #1;
    endtask

    // Starts in the first IF cycle of an instruction; returns once the next IF begins.
    task automatic run_instr(input logic [31:0] ir, input logic bt, input int di, input int dd,
                             output int cyc, output int n_rf, output int n_sel, output int n_dreq,
                             output int n_dwe, output int n_pcwe, output bit ok);
        int  if_n, mem_n;
        bit  left;
        cyc = 0; n_rf = 0; n_sel = 0; n_dreq = 0; n_dwe = 0; n_pcwe = 0; ok = 1'b0;
        if_n = 0; mem_n = 0; left = 1'b0;
        w_ir = ir; w_br_taken = bt; w_run = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (w_state == 3'd1 && left) begin
                ok = 1'b1;
                return;
            end
            if (w_state != 3'd1) left = 1'b1;
            w_imem_ack = w_imem_req ? (if_n == di) : 1'($urandom_range(0, 1));
            w_dmem_ack = w_dmem_req ? (mem_n == dd) : 1'($urandom_range(0, 1));
            #1;
            if (w_state >= 3'd1 && w_state <= 3'd5) cyc++;
            n_rf   += int'(w_rf_we);
            n_sel  += int'(w_pc_we && w_pc_sel);
            n_pcwe += int'(w_pc_we);
            n_dreq += int'(w_dmem_req);
            n_dwe  += int'(w_dmem_req && w_dmem_we);
            if (w_imem_req) if_n++;
            if (w_dmem_req) mem_n++;
            tick();
        end
    endtask

    task automatic check_instr(input string nm, input logic [31:0] ir, input logic bt,
                               input int di, input int dd, input int e_cyc, input int e_rf,
                               input int e_sel, input int e_dreq, input int e_dwe);
        int cyc, n_rf, n_sel, n_dreq, n_dwe, n_pcwe;
        bit ok;
        logic [31:0] ret0, cc0;
        ret0 = w_retired;
        cc0  = w_cycle_cnt;
        run_instr(ir, bt, di, dd, cyc, n_rf, n_sel, n_dreq, n_dwe, n_pcwe, ok);
        chk({nm, " completed"}, ok, 1);
        chk({nm, " cycles"}, cyc, e_cyc);
        chk({nm, " cycle_cnt delta"}, w_cycle_cnt - cc0, e_cyc);
        chk({nm, " retired delta"}, w_retired - ret0, 1);
        chk({nm, " rf_we cycles"}, n_rf, e_rf);
        chk({nm, " pc_sel=1 cycles"}, n_sel, e_sel);
        chk({nm, " pc_we cycles"}, n_pcwe, 1);
        chk({nm, " dmem_req cycles"}, n_dreq, e_dreq);
        chk({nm, " dmem_we cycles"}, n_dwe, e_dwe);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_tr[6];
        int n;
        logic [31:0] ret0, cc0;
        exp_tr = '{0, 1, 2, 3, 5, 1};

        //           ir            bt    di dd cyc rf sel dreq dwe
        tbl[0] = '{32'h001080B3, 1'b0, 0, 0, 4, 1, 0, 0, 0};
        tbl[1] = '{32'h0000A103, 1'b0, 0, 2, 7, 1, 0, 3, 0};
        tbl[2] = '{32'h0020A023, 1'b0, 0, 0, 4, 0, 0, 1, 1};
        tbl[3] = '{32'h00000063, 1'b1, 0, 0, 3, 0, 1, 0, 0};
        tbl[4] = '{32'h00000063, 1'b0, 0, 0, 3, 0, 0, 0, 0};
        tbl[5] = '{32'h00000013, 1'b0, 0, 0, 4, 0, 0, 0, 0};
        tbl[6] = '{32'h00500293, 1'b0, 3, 0, 7, 1, 0, 0, 0};
        tbl[7] = '{32'h0020A023, 1'b1, 1, 1, 6, 0, 0, 2, 2};

        w_reset = 1'b1; w_run = 1'b1; w_ir = 32'h001080B3; w_br_taken = 1'b0;
        w_imem_ack = 1'b1; w_dmem_ack = 1'b0;

        tick();
        chk("reset state", w_state, 0);
        chk("reset cycle_cnt", w_cycle_cnt, 0);
        chk("reset retired", w_retired, 0);
        chk("reset illegal", w_illegal, 0);
        chk("reset fault", w_fault, 0);
        chk("reset halted", w_halted, 0);
        chk("reset imem_req", w_imem_req, 0);
        w_reset = 1'b0;

        for (int i = 1; i < 6; i++) begin
            tick();
            chk($sformatf("add trace step %0d", i), w_state, exp_tr[i]);
            if (exp_tr[i] == 5) begin
                chk("add WB rf_we", w_rf_we, 1);
                chk("add WB pc_we", w_pc_we, 1);
                chk("add WB pc_sel", w_pc_sel, 0);
            end
        end
        chk("add retired", w_retired, 1);
        chk("add cycle_cnt", w_cycle_cnt, 4);

        for (int i = 0; i < 8; i++)
            check_instr($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].bt, tbl[i].di, tbl[i].dd,
                        tbl[i].cyc, tbl[i].rf, tbl[i].sel, tbl[i].dreq, tbl[i].dwe);

        // Random stream: expected effects from instruction class and ack delays alone
        for (int i = 0; i < 40; i++) begin
            int cls, di, dd, e_cyc, e_rf, e_sel, e_dreq, e_dwe;
            logic [6:0]  opc;
            logic [4:0]  rd;
            logic        bt;
            logic [31:0] ir;
            cls = $urandom_range(0, 4);
            di  = $urandom_range(0, 3);
            dd  = $urandom_range(0, 3);
            rd  = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31));
            bt  = 1'($urandom_range(0, 1));
            case (cls)
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                default: opc = 7'b1100011;
            endcase
            ir = ($urandom & 32'hFFFFF000) | {20'd0, rd, opc};
            e_cyc  = (di + 1) + 1;
            e_rf   = 0;
            e_sel  = 0;
            e_dreq = 0;
            e_dwe  = 0;
            case (cls)
                0, 1: begin e_cyc += 2; e_rf = (rd != 0); end
                2: begin e_cyc += 1 + (dd + 1) + 1; e_rf = (rd != 0); e_dreq = dd + 1; end
                3: begin e_cyc += 1 + (dd + 1); e_dreq = dd + 1; e_dwe = dd + 1; end
                default: begin e_cyc += 1; e_sel = int'(bt); end
            endcase
            check_instr($sformatf("rnd%0d cls%0d", i, cls), ir, bt, di, dd,
                        e_cyc, e_rf, e_sel, e_dreq, e_dwe);
        end

        // Drop w_run during EX: addi x0 must still finish, then park in IDLE
        ret0 = w_retired;
        w_ir = 32'h00000013; w_imem_ack = 1'b1; w_dmem_ack = 1'b0;
        tick();
        chk("runoff ID", w_state, 2);
        tick();
        chk("runoff EX", w_state, 3);
        w_run = 1'b0;
        tick();
        chk("runoff WB", w_state, 5);
        chk("runoff WB rf_we", w_rf_we, 0);
        chk("runoff WB pc_we", w_pc_we, 1);
        tick();
        chk("runoff IDLE", w_state, 0);
        chk("runoff retired", w_retired - ret0, 1);

        // Illegal opcode: HALT, not retired, deaf to w_run
        ret0 = w_retired; cc0 = w_cycle_cnt;
        w_ir = 32'hFFFFFFFF; w_run = 1'b1;
        tick(); tick(); tick();
        chk("illegal state", w_state, 6);
        chk("illegal flag", w_illegal, 1);
        chk("illegal halted", w_halted, 1);
        chk("illegal fault", w_fault, 0);
        chk("illegal retired", w_retired - ret0, 0);
        for (int i = 0; i < 4; i++) begin
            w_run = ~w_run;
            tick();
        end
        chk("illegal sticky state", w_state, 6);
        chk("illegal imem_req", w_imem_req, 0);
        chk("illegal cycle_cnt frozen", w_cycle_cnt - cc0, 2);

        // ecall retires and halts without flagging illegal
        w_reset = 1'b1; tick(); w_reset = 1'b0;
        chk("post-reset illegal", w_illegal, 0);
        w_ir = 32'h00000073; w_run = 1'b1;
        tick(); tick(); tick();
        chk("ecall state", w_state, 6);
        chk("ecall illegal", w_illegal, 0);
        chk("ecall retired", w_retired, 1);

        // Fetch timeout on dut; dut_s never times out and its counter saturates
        w_reset = 1'b1; tick(); w_reset = 1'b0;
        w_imem_ack = 1'b0; w_run = 1'b1;
        tick();
        n = 0;
        for (int k = 0; k < 30; k++) begin
            if (w_state == 3'd1) n++;
            tick();
        end
        chk("timeout IF cycles", n, 8);
        chk("timeout state", w_state, 6);
        chk("timeout fault", w_fault, 1);
        chk("timeout illegal", w_illegal, 0);
        chk("timeout cycle_cnt", w_cycle_cnt, 8);
        chk("no-timeout state", s_state, 1);
        chk("no-timeout halted", s_halted, 0);
        chk("saturated cycle_cnt", s_cycle_cnt, 7);

        // Reset while a load sits in MEM
        w_reset = 1'b1; tick(); w_reset = 1'b0;
        chk("fault cleared", w_fault, 0);
        tick();
        begin
            int cyc, a, b, c, d, e;
            bit ok;
            run_instr(32'h001080B3, 1'b0, 0, 0, cyc, a, b, c, d, e, ok);
            chk("pre-MEM add done", ok, 1);
        end
        w_ir = 32'h0000A103; w_imem_ack = 1'b1; w_dmem_ack = 1'b0;
        n = 0;
        while (w_state != 3'd4 && n < 10) begin
            tick();
            n++;
        end
        chk("reached MEM", w_state, 4);
        tick();
        chk("held in MEM dmem_req", w_dmem_req, 1);
        chk("pre-reset retired", w_retired, 1);
        w_reset = 1'b1;
        tick();
        w_reset = 1'b0; w_run = 1'b0; w_dmem_ack = 1'b1;
        #1;
        chk("mid-MEM reset state", w_state, 0);
        chk("mid-MEM reset dmem_req", w_dmem_req, 0);
        chk("mid-MEM reset retired", w_retired, 0);
        chk("mid-MEM reset cycle_cnt", w_cycle_cnt, 0);
        tick();
        chk("stray dmem_ack ignored", w_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
